// File: rtl/pwm_envelope_gen.sv
// pwm_envelope_gen: PWM generator whose duty follows a slow envelope index (square/saw/triangle/hold)
// Ports:
//   sysclk      rising-edge clock
//   rst         asynchronous active-high reset
//   enable      gates the pulse outputs; counters keep running
//   mode        00 square, 01 saw, 10 triangle, 11 hold; sampled at frame wrap
//   duty_in     hold-mode duty, saturated to 2^PWM_W; sampled at PWM wrap
//   pulse       registered PWM output
//   pulse_n     complementary output with DEAD-clock blanking (only with COMPL_OUT_EN)
//   duty        duty currently in effect
//   frame_strb  one-clock strobe as the envelope index wraps to 0
// Optional feature macro: COMPL_OUT_EN adds pulse_n and the dead-time logic.
module pwm_envelope_gen #(
  parameter int PWM_W = 6,
  parameter int IDX_W = 6,
  parameter int DEAD  = 2
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [PWM_W:0]   duty_in,
  output logic             pulse,
`ifdef COMPL_OUT_EN
  output logic             pulse_n,
`endif
  output logic [PWM_W:0]   duty,
  output logic             frame_strb
);
  localparam logic [PWM_W:0]   FULL = {1'b1, {PWM_W{1'b0}}};
  localparam logic [IDX_W-1:0] Q    = {2'b01, {(IDX_W-2){1'b0}}};
  localparam logic [IDX_W-1:0] Q3   = {2'b11, {(IDX_W-2){1'b0}}};
  logic [PWM_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [PWM_W:0]   duty_q, duty_d, sq, saw, tri_v, hold;
  logic [IDX_W-2:0] t;
  logic [IDX_W-1:0] tw;
  logic             pulse_q, pulse_d, strb_q, wrap, fwrap, raw;
  assign wrap  = &cnt_q;
  assign fwrap = wrap & (&idx_q);
  assign idx_d = idx_q + IDX_W'(1);
  // the mode that governs the frame starting at this wrap also picks its first duty
  assign mode_d = fwrap ? mode : mode_q;
  always_comb begin
    t      = idx_d[IDX_W-1] ? ~idx_d[IDX_W-2:0] : idx_d[IDX_W-2:0];
    tw     = {t, 1'b0};
    sq     = (idx_d >= Q && idx_d < Q3) ? FULL : '0;
    saw    = {1'b0, idx_d[IDX_W-1 -: PWM_W]};
    tri_v  = {1'b0, tw[IDX_W-1 -: PWM_W]};
    hold   = (duty_in > FULL) ? FULL : duty_in;
    duty_d = !wrap ? duty_q :
             mode_d == 2'b00 ? sq :
             mode_d == 2'b01 ? saw :
             mode_d == 2'b10 ? tri_v : hold;
  end
  assign raw = enable & ({1'b0, cnt_q} < duty_q);
`ifdef COMPL_OUT_EN
  logic             raw_q, pn_q, pn_d;
  logic [PWM_W-1:0] dead_q, dead_d;
  // any edge of the raw pulse blanks both outputs until the dead counter drains
  always_comb begin
    dead_d  = (raw != raw_q) ? PWM_W'(DEAD) : (dead_q == '0) ? '0 : dead_q - PWM_W'(1);
    pulse_d = raw & (dead_d == '0);
    pn_d    = enable & ~raw & (dead_d == '0);
  end
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      raw_q  <= 1'b0;
      dead_q <= '0;
      pn_q   <= 1'b0;
    end else begin
      raw_q  <= raw;
      dead_q <= dead_d;
      pn_q   <= pn_d;
    end
  end
  assign pulse_n = pn_q;
`else
  assign pulse_d = raw;
`endif
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 2'b00;
      duty_q  <= '0;
      pulse_q <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + PWM_W'(1);
      idx_q   <= wrap ? idx_d : idx_q;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      pulse_q <= pulse_d;
      strb_q  <= fwrap;
    end
  end
  assign pulse      = pulse_q;
  assign duty       = duty_q;
  assign frame_strb = strb_q;
endmodule

// File: tb/tb_pwm_envelope_gen.sv
// tb_pwm_envelope_gen: directed self-checking bench for pwm_envelope_gen (default parameters)
module tb_pwm_envelope_gen;
  logic       sysclk, rst, enable;
  logic [1:0] mode;
  logic [6:0] duty_in;
  logic       pulse, frame_strb;
  logic [6:0] duty;
  int         errors, checks, cyc, hi, rises;
  logic       prev;
`ifdef COMPL_OUT_EN
  logic       pulse_n;
`endif
  pwm_envelope_gen dut (
    .sysclk(sysclk), .rst(rst), .enable(enable), .mode(mode), .duty_in(duty_in),
    .pulse(pulse),
`ifdef COMPL_OUT_EN
    .pulse_n(pulse_n),
`endif
    .duty(duty), .frame_strb(frame_strb)
  );
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at cyc=%0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
`ifdef COMPL_OUT_EN
    chk("never_both_high", {31'd0, pulse & pulse_n}, 32'd0);
`endif
  endtask
  task automatic adv_to(input int k);
    while (cyc < k) tick();
  endtask
  initial begin
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b1; enable = 1'b1; mode = 2'b00; duty_in = 7'd0;
    tick(); tick();
    chk("rst_pulse", {31'd0, pulse}, 32'd0);
    chk("rst_duty", {25'd0, duty}, 32'd0);
    chk("rst_strb", {31'd0, frame_strb}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    // square frame; mode switched to saw mid-frame must not affect it
    hi = 0; rises = 0; prev = 1'b0;
    while (!frame_strb && cyc < 5000) begin
      tick();
      if (pulse) hi++;
      if (pulse && !prev) rises++;
      prev = pulse;
      if (cyc % 64 == 32) chk("sq_duty", {25'd0, duty}, (cyc / 64 >= 16 && cyc / 64 < 48) ? 32'd64 : 32'd0);
      if (cyc == 2000) mode = 2'b01;
    end
    chk("first_strb_cyc", cyc, 4096);
    chk("sq_high_clocks", hi, 2048);
    chk("sq_contiguous", rises, 1);
    // saw frame
    adv_to(4160);
    chk("saw_idx1", {25'd0, duty}, 32'd1);
    adv_to(6144);
    chk("saw_idx32", {25'd0, duty}, 32'd32);
    chk("saw_cnt0_pulse", {31'd0, pulse}, 32'd0);
    adv_to(6145);
    chk("saw_cnt1_pulse", {31'd0, pulse}, 32'd1);
    hi = 1;
    repeat (63) begin
      tick();
      if (pulse) hi++;
    end
    chk("saw_high_clocks", hi, 32);
    adv_to(7000);
    mode = 2'b10;
    adv_to(8191);
    chk("saw_idx63", {25'd0, duty}, 32'd63);
    // triangle frame; hold with oversize duty requested mid-frame
    for (int i = 0; i < 64; i++) begin
      adv_to(8192 + 64 * i + 32);
      chk("tri_duty", {25'd0, duty}, i < 32 ? 2 * i : 2 * (63 - i));
      if (i == 40) begin
        mode = 2'b11;
        duty_in = 7'd100;
      end
    end
    adv_to(12287);
    chk("strb_before", {31'd0, frame_strb}, 32'd0);
    adv_to(12288);
    chk("strb_at_wrap", {31'd0, frame_strb}, 32'd1);
    adv_to(12289);
    chk("strb_one_clock", {31'd0, frame_strb}, 32'd0);
    // hold frame
    adv_to(12288 + 128);
    chk("hold_saturate", {25'd0, duty}, 32'd64);
    hi = 0;
    repeat (512) begin
      tick();
      if (pulse) hi++;
    end
    chk("hold_const_high", hi, 512);
    adv_to(12288 + 700);
    duty_in = 7'd40;
    adv_to(12288 + 64 * 12 + 1);
    chk("hold_duty40", {25'd0, duty}, 32'd40);
    adv_to(13500);
    mode = 2'b01;
    adv_to(16000);
    chk("switch_not_yet", {25'd0, duty}, 32'd40);
    adv_to(16384);
    chk("switch_strb", {31'd0, frame_strb}, 32'd1);
    adv_to(16384 + 64 * 5 + 3);
    chk("switch_saw_idx5", {25'd0, duty}, 32'd5);
    // enable gating at duty 32
    adv_to(18442);
    chk("en_pulse_before", {31'd0, pulse}, 32'd1);
    enable = 1'b0;
    tick();
    chk("en_low_pulse", {31'd0, pulse}, 32'd0);
    chk("en_low_duty", {25'd0, duty}, 32'd32);
    adv_to(18463);
    chk("en_low_hold", {31'd0, pulse}, 32'd0);
    enable = 1'b1;
    tick();
    chk("en_back_pulse", {31'd0, pulse}, 32'd1);
    tick();
    chk("en_back_cnt32", {31'd0, pulse}, 32'd0);
    // asynchronous reset in the middle of a pulse
    adv_to(18500);
    chk("pre_rst_pulse", {31'd0, pulse}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pulse", {31'd0, pulse}, 32'd0);
    chk("async_rst_duty", {25'd0, duty}, 32'd0);
    chk("async_rst_strb", {31'd0, frame_strb}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    cyc = 0;
    while (!frame_strb && cyc < 5000) begin
      tick();
      if (cyc == 32 * 64 + 5) chk("rst_square_mid", {25'd0, duty}, 32'd64);
      if (cyc == 5) chk("rst_idx0_duty", {25'd0, duty}, 32'd0);
    end
    chk("rst_first_strb", cyc, 4096);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
